// File: rtl/diode_norm_lut_if.sv
// Handshake bundle between the diode window controller and the normalisation LUT.
// The master side drives the trigger and sample inputs; the slave side produces the coefficient.
interface diode_norm_lut_if;
    logic               useDiode;
    logic               trig;
    logic [7:0]         windowLen;
    logic signed [12:0] diodeIn;
    logic signed [17:0] lutReg;
    logic               lutValid;
    logic               lowDiode;
    logic               busy;
    logic               trigOverlap;

    modport master (
        output useDiode, trig, windowLen, diodeIn,
        input  lutReg, lutValid, lowDiode, busy, trigOverlap
    );

    modport slave (
        input  useDiode, trig, windowLen, diodeIn,
        output lutReg, lutValid, lowDiode, busy, trigOverlap
    );
endinterface

// File: rtl/diode_norm_lut.sv
// Integrates a window of diode samples and looks up a reciprocal-square-root coefficient.
// The coefficient drives the normalising multiplier; unity is forced while normalisation is off.
module diode_norm_lut #(
    parameter int ADDR_W    = 10,
    parameter int SUM_SHIFT = 8,
    parameter int LUT_SCALE = 16,
    parameter int MIN_INDEX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    diode_norm_lut_if.slave   bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] INTEG = 3'd1;
    localparam logic [2:0] INDEX = 3'd2;
    localparam logic [2:0] READ  = 3'd3;
    localparam logic [2:0] LOAD  = 3'd4;
    localparam int         DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] IDX_MAX = {ADDR_W{1'b1}};

    // round(2^S / sqrt(k)) computed as (isqrt(2^(2S+2)/k) + 1) / 2, clipped to 17 bits
    function automatic logic [16:0] rom_val(input int k);
        logic [63:0] num;
        logic [63:0] t;
        logic [63:0] y;
        logic [63:0] r;
        if (k == 0) begin
            return 17'd0;
        end
        num = (64'd1 << (2 * LUT_SCALE + 2)) / 64'(k);
        y   = 64'd0;
        for (int b = LUT_SCALE + 1; b >= 0; b--) begin
            t = y | (64'd1 << b);
            if (t * t <= num) begin
                y = t;
            end
        end
        r = (y + 64'd1) >> 1;
        if (r > 64'd131071) begin
            r = 64'd131071;
        end
        return r[16:0];
    endfunction

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    logic [7:0]        r_cnt;
    logic [19:0]       r_acc;
    logic [ADDR_W-1:0] r_index;
    logic [16:0]       r_rom;
    logic signed [17:0] r_lut;
    logic              r_valid;
    logic              r_low;
    logic              r_busy;
    logic              r_ovl;
    logic [19:0]       w_sample;
    logic [19:0]       w_shifted;
    logic [ADDR_W-1:0] w_index;
    logic              w_low;
    logic [16:0]       w_rom [DEPTH];

    // Constant coefficient table, one elaboration-time entry per address
    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam logic [16:0] ENTRY = rom_val(k);
        assign w_rom[k] = ENTRY;
    end

    // Negative samples clamp to zero; positive range fits in 12 bits
    always_comb begin
        w_sample  = 20'd0;
        w_shifted = r_acc >> SUM_SHIFT;
        w_index   = w_shifted[ADDR_W-1:0];
        if (bus.diodeIn[12]) begin
            w_sample = 20'd0;
        end else begin
            w_sample = {8'd0, bus.diodeIn[11:0]};
        end
        if (w_shifted > 20'(IDX_MAX)) begin
            w_index = IDX_MAX;
        end else begin
            w_index = w_shifted[ADDR_W-1:0];
        end
        w_low = (32'(r_index) < MIN_INDEX);
    end

    // Next-state logic for the measurement sequence
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.trig && (bus.windowLen != 8'd0)) begin
                    w_state_next = INTEG;
                end else begin
                    w_state_next = IDLE;
                end
            end
            INTEG: begin
                if (r_cnt == 8'd1) begin
                    w_state_next = INDEX;
                end else begin
                    w_state_next = INTEG;
                end
            end
            INDEX:   w_state_next = READ;
            READ:    w_state_next = LOAD;
            LOAD:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State, integration datapath and ROM read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_acc   <= 20'd0;
            r_index <= '0;
            r_rom   <= 17'd0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (bus.trig && (bus.windowLen != 8'd0)) begin
                        r_cnt <= bus.windowLen;
                        r_acc <= 20'd0;
                    end
                end
                INTEG: begin
                    r_acc <= r_acc + w_sample;
                    r_cnt <= r_cnt - 8'd1;
                end
                INDEX:   r_index <= w_index;
                READ:    r_rom   <= w_rom[r_index];
                default: r_cnt   <= r_cnt;
            endcase
        end
    end

    // Registered outputs; disabled normalisation overrides the coefficient every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lut   <= 18'sd0;
            r_valid <= 1'b0;
            r_low   <= 1'b0;
            r_busy  <= 1'b0;
            r_ovl   <= 1'b0;
        end else begin
            r_busy  <= (w_state_next != IDLE);
            r_ovl   <= bus.trig && (r_state != IDLE);
            r_valid <= (r_state == LOAD);
            if (!bus.useDiode) begin
                r_lut <= 18'sd1;
            end else if (r_state == LOAD) begin
                r_lut <= w_low ? 18'sd0 : $signed({1'b0, r_rom});
            end else begin
                r_lut <= r_lut;
            end
            if (r_state == LOAD) begin
                r_low <= bus.useDiode && w_low;
            end else begin
                r_low <= r_low;
            end
        end
    end

    assign bus.lutReg      = r_lut;
    assign bus.lutValid    = r_valid;
    assign bus.lowDiode    = r_low;
    assign bus.busy        = r_busy;
    assign bus.trigOverlap = r_ovl;
endmodule

// File: tb/tb_diode_norm_lut.sv
// Scoreboard bench for diode_norm_lut: directed windows push expected coefficients,
// a negedge monitor pops them whenever lutValid is seen.
module tb_diode_norm_lut;
    logic clk;
    logic rst_n;
    diode_norm_lut_if bus ();

    diode_norm_lut dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_valid = 0;
    logic [18:0] exp_q [$];
    logic signed [12:0] samp [256];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every lutValid pulse must match the oldest expected result
    always @(negedge clk) begin
        if (rst_n && bus.lutValid) begin
            logic [18:0] e;
            n_valid++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got lutReg %0d with no expected entry", bus.lutReg);
            end else begin
                e = exp_q.pop_front();
                chk("lutReg", bus.lutReg, $signed(e[18:1]));
                chk("lowDiode", bus.lowDiode, e[0]);
            end
        end
    end

    task automatic fill(input int n, input logic signed [12:0] v);
        for (int i = 0; i < n; i++) samp[i] = v;
    endtask

    task automatic run_win(input int n, input bit ovl, input bit fire,
                           input logic signed [17:0] e_lut, input bit e_low);
        int vat;
        int ovc;
        int bcnt;
        if (fire) exp_q.push_back({e_lut, e_low});
        @(negedge clk);
        bus.trig      = 1'b1;
        bus.windowLen = n[7:0];
        vat  = -1;
        ovc  = 0;
        bcnt = 0;
        for (int c = 1; c <= n + 8; c++) begin
            @(negedge clk);
            bus.trig    = ovl && (c == 2 || c == n + 3);
            bus.diodeIn = (c <= n) ? samp[c-1] : 13'sd0;
            if (bus.lutValid && vat < 0) vat = c;
            if (bus.trigOverlap) ovc++;
            if (bus.busy) bcnt++;
        end
        chk("valid_cycle", vat, fire ? n + 4 : -1);
        chk("busy_cycles", bcnt, fire ? n + 3 : 0);
        chk("overlap_pulses", ovc, ovl ? 2 : 0);
    endtask

    initial begin
        int vb;
        rst_n         = 1'b0;
        bus.useDiode  = 1'b0;
        bus.trig      = 1'b0;
        bus.windowLen = 8'd0;
        bus.diodeIn   = 13'sd0;
        #1;
        chk("rst_lutReg", bus.lutReg, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.lutValid, 0);
        repeat (2) @(negedge clk);
        chk("rst_hold_lutReg", bus.lutReg, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("bypass_first_edge", bus.lutReg, 1);

        // Bypass window still produces a valid pulse with unity
        fill(4, 13'sd1024);
        run_win(4, 1'b0, 1'b1, 18'sd1, 1'b0);
        bus.useDiode = 1'b1;
        repeat (3) @(negedge clk);
        chk("enable_keeps_unity", bus.lutReg, 1);

        // Nominal: sum 4096, index 16
        run_win(4, 1'b0, 1'b1, 18'sd16384, 1'b0);
        chk("hold_after_load", bus.lutReg, 16384);

        // Clamping: negative sample ignored, sum 1024, index 4
        samp[0] = 13'sd256; samp[1] = -13'sd100; samp[2] = 13'sd256; samp[3] = 13'sd512;
        run_win(4, 1'b0, 1'b1, 18'sd32768, 1'b0);
        fill(4, 13'sd2);
        run_win(4, 1'b0, 1'b1, 18'sd0, 1'b1);
        fill(1, 13'sd768);
        run_win(1, 1'b0, 1'b1, 18'sd0, 1'b1);

        // Saturation: index clipped to 1023
        fill(255, 13'sd4095);
        run_win(255, 1'b0, 1'b1, 18'sd2049, 1'b0);

        // Overlap and zero-length trigger
        fill(4, 13'sd1024);
        run_win(4, 1'b1, 1'b1, 18'sd16384, 1'b0);
        run_win(0, 1'b0, 1'b0, 18'sd0, 1'b0);

        // Reset asserted at cycle 2 of an 8-sample window
        fill(8, 13'sd1024);
        @(negedge clk);
        bus.trig = 1'b1;
        bus.windowLen = 8'd8;
        @(negedge clk);
        bus.trig = 1'b0;
        bus.diodeIn = 13'sd1024;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_lutReg", bus.lutReg, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_low", bus.lowDiode, 0);
        @(negedge clk);
        rst_n = 1'b1;
        vb = n_valid;
        repeat (20) @(negedge clk);
        chk("mid_rst_no_valid", n_valid - vb, 0);
        chk("mid_rst_idle_busy", bus.busy, 0);
        run_win(4, 1'b0, 1'b1, 18'sd16384, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
